// File: rtl/mcu_writer_pkg.sv
// Shared definitions for the result writer: FSM state encoding and the
// fixed AXI-lite field values used on the write channels.
package mcu_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WRITE = 3'd2,
      ST_RESP  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
   localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

   // True when the stream's tlast marker disagrees with the beat count.
   function automatic logic tlast_mismatch(input logic tlast, input logic last_expected);
      return tlast != last_expected;
   endfunction

endpackage

// File: rtl/mcu_result_axil_writer_if.sv
// Bundle of the result stream (slave side of the writer) and the AXI-lite
// write channels (master side of the writer).
interface mcu_result_axil_writer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;

   logic [ADDR_WIDTH-1:0] m_axil_awaddr;
   logic [2:0]            m_axil_awprot;
   logic                  m_axil_awvalid;
   logic                  m_axil_awready;
   logic [DATA_WIDTH-1:0] m_axil_wdata;
   logic [STRB_WIDTH-1:0] m_axil_wstrb;
   logic                  m_axil_wvalid;
   logic                  m_axil_wready;
   logic [1:0]            m_axil_bresp;
   logic                  m_axil_bvalid;
   logic                  m_axil_bready;

   // Writer view: consumes the stream, drives the AXI-lite write master.
   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
      input  m_axil_awready,
      output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
      input  m_axil_wready,
      input  m_axil_bresp, m_axil_bvalid,
      output m_axil_bready
   );

   // Environment view: stream producer plus AXI-lite memory slave.
   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
      output m_axil_awready,
      input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
      output m_axil_wready,
      output m_axil_bresp, m_axil_bvalid,
      input  m_axil_bready
   );

endinterface

// File: rtl/mcu_result_axil_writer.sv
// Drains the result stream and writes each beat to consecutive word
// addresses over AXI-lite, one write outstanding at a time. Reports busy,
// a one-cycle complete pulse and a coincident error pulse per run.
module mcu_result_axil_writer
   import mcu_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  fsm_clk,
   input  logic                  rst,
   input  logic                  operation_start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   data_size,
   output logic                  operation_busy,
   output logic                  operation_complete,
   output logic                  operation_error,
   mcu_result_axil_writer_if.master bus
);

   localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(STRB_WIDTH);

   state_t                state_q;
   state_t                state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   remaining_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  aw_pend_q;
   logic                  w_pend_q;

   logic                  stream_hs;
   logic                  aw_done;
   logic                  w_done;
   logic                  last_expected;

   // A channel counts as finished once its valid has dropped or its
   // handshake is happening in this cycle.
   assign stream_hs     = (state_q == ST_FETCH) && bus.s_axis_tvalid;
   assign aw_done       = !aw_pend_q || bus.m_axil_awready;
   assign w_done        = !w_pend_q  || bus.m_axil_wready;
   assign last_expected = (remaining_q == REM_ONE);

   assign bus.m_axil_awaddr  = addr_q;
   assign bus.m_axil_awprot  = AXIL_PROT_DEFAULT;
   assign bus.m_axil_awvalid = aw_pend_q;
   assign bus.m_axil_wdata   = data_q;
   assign bus.m_axil_wstrb   = '1;
   assign bus.m_axil_wvalid  = w_pend_q;

   // State register.
   always_ff @(posedge fsm_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and the state-derived handshake/status outputs.
   always_comb begin
      state_d            = state_q;
      bus.s_axis_tready  = 1'b0;
      bus.m_axil_bready  = 1'b0;
      operation_busy     = 1'b0;
      operation_complete = 1'b0;
      operation_error    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (operation_start) begin
               state_d = (data_size == REM_ZERO) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            operation_busy    = 1'b1;
            bus.s_axis_tready = 1'b1;
            if (bus.s_axis_tvalid) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            operation_busy = 1'b1;
            if (aw_done && w_done) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            operation_busy    = 1'b1;
            bus.m_axil_bready = 1'b1;
            if (bus.m_axil_bvalid) begin
               state_d = (remaining_q == REM_ONE) ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: begin
            operation_complete = 1'b1;
            operation_error    = err_q;
            state_d            = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Run bookkeeping: address/remaining counters, error flag, captured
   // beat and the per-channel pending flags that drive awvalid/wvalid.
   always_ff @(posedge fsm_clk) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
         data_q      <= '0;
         aw_pend_q   <= 1'b0;
         w_pend_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (operation_start) begin
                  addr_q      <= base_addr;
                  remaining_q <= data_size;
                  // A zero-size run must not report a stale error either.
                  err_q       <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (stream_hs) begin
                  data_q    <= bus.s_axis_tdata;
                  aw_pend_q <= 1'b1;
                  w_pend_q  <= 1'b1;
                  if (tlast_mismatch(bus.s_axis_tlast, last_expected)) begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (aw_pend_q && bus.m_axil_awready) begin
                  aw_pend_q <= 1'b0;
               end
               if (w_pend_q && bus.m_axil_wready) begin
                  w_pend_q <= 1'b0;
               end
            end
            ST_RESP: begin
               if (bus.m_axil_bvalid) begin
                  if (bus.m_axil_bresp != AXI_RESP_OKAY) begin
                     err_q <= 1'b1;
                  end
                  remaining_q <= remaining_q - REM_ONE;
                  addr_q      <= addr_q + ADDR_INC;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_result_axil_writer.sv
// Directed bench for mcu_result_axil_writer: a table-driven stream source,
// an AXI-lite slave with programmable AW/W ready delays and an injectable
// bad response, and one task per scenario.
module tb_mcu_result_axil_writer;

   logic        fsm_clk;
   logic        rst;
   logic        operation_start;
   logic [31:0] base_addr;
   logic [32:0] data_size;
   logic        operation_busy;
   logic        operation_complete;
   logic        operation_error;

   mcu_result_axil_writer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

   mcu_result_axil_writer #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
      .fsm_clk            (fsm_clk),
      .rst                (rst),
      .operation_start    (operation_start),
      .base_addr          (base_addr),
      .data_size          (data_size),
      .operation_busy     (operation_busy),
      .operation_complete (operation_complete),
      .operation_error    (operation_error),
      .bus                (bus)
   );

   initial fsm_clk = 1'b0;
   always #5 fsm_clk = ~fsm_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Environment configuration (written by the test process only).
   logic [15:0] s_data [8];
   logic        s_last [8];
   int          s_len = 0;
   int          aw_delay = 0;
   int          w_delay = 0;
   int          bad_beat = -1;
   logic        tb_clr = 1'b0;

   // Environment state (written by the slave process only).
   int          s_idx = 0;
   int          aw_wait = 0;
   int          w_wait = 0;
   int          n_aw = 0;
   int          n_w = 0;
   int          n_b = 0;
   int          stab_err = 0;
   logic        got_aw = 1'b0;
   logic        got_w = 1'b0;
   logic        sl_bvalid = 1'b0;
   logic [1:0]  sl_bresp = 2'b00;
   logic        p_aw_hold = 1'b0;
   logic        p_w_hold = 1'b0;
   logic [31:0] p_awaddr = '0;
   logic [15:0] p_wdata = '0;
   logic [31:0] log_awaddr [16];
   logic [15:0] log_wdata [16];

   logic hs_aw, hs_w;

   assign bus.s_axis_tvalid  = (s_idx < s_len);
   assign bus.s_axis_tdata   = s_data[s_idx[2:0]];
   assign bus.s_axis_tlast   = s_last[s_idx[2:0]];
   assign bus.m_axil_awready = bus.m_axil_awvalid && (aw_wait >= aw_delay);
   assign bus.m_axil_wready  = bus.m_axil_wvalid && (w_wait >= w_delay);
   assign bus.m_axil_bvalid  = sl_bvalid;
   assign bus.m_axil_bresp   = sl_bresp;
   assign hs_aw = bus.m_axil_awvalid && bus.m_axil_awready;
   assign hs_w  = bus.m_axil_wvalid && bus.m_axil_wready;

   // Stream source, AXI-lite slave, transaction logs and stability monitor.
   always @(posedge fsm_clk) begin
      if (tb_clr) begin
         s_idx <= 0; n_aw <= 0; n_w <= 0; n_b <= 0; stab_err <= 0;
      end
      if (rst || tb_clr) begin
         got_aw <= 1'b0; got_w <= 1'b0; sl_bvalid <= 1'b0; sl_bresp <= 2'b00;
         aw_wait <= 0; w_wait <= 0; p_aw_hold <= 1'b0; p_w_hold <= 1'b0;
      end else begin
         if (bus.s_axis_tvalid && bus.s_axis_tready) s_idx <= s_idx + 1;
         if (hs_aw) begin
            log_awaddr[n_aw[3:0]] <= bus.m_axil_awaddr;
            n_aw <= n_aw + 1;
            aw_wait <= 0;
         end else if (bus.m_axil_awvalid) begin
            aw_wait <= aw_wait + 1;
         end
         if (hs_w) begin
            log_wdata[n_w[3:0]] <= bus.m_axil_wdata;
            n_w <= n_w + 1;
            w_wait <= 0;
         end else if (bus.m_axil_wvalid) begin
            w_wait <= w_wait + 1;
         end
         if ((got_aw || hs_aw) && (got_w || hs_w)) begin
            sl_bvalid <= 1'b1;
            sl_bresp  <= (n_b == bad_beat) ? 2'b10 : 2'b00;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
         end else begin
            if (hs_aw) got_aw <= 1'b1;
            if (hs_w)  got_w  <= 1'b1;
         end
         if (sl_bvalid && bus.m_axil_bready) begin
            sl_bvalid <= 1'b0;
            n_b <= n_b + 1;
         end
         if (p_aw_hold && (!bus.m_axil_awvalid || bus.m_axil_awaddr != p_awaddr)) stab_err <= stab_err + 1;
         if (p_w_hold && (!bus.m_axil_wvalid || bus.m_axil_wdata != p_wdata)) stab_err <= stab_err + 1;
         p_aw_hold <= bus.m_axil_awvalid && !bus.m_axil_awready;
         p_w_hold  <= bus.m_axil_wvalid && !bus.m_axil_wready;
         p_awaddr  <= bus.m_axil_awaddr;
         p_wdata   <= bus.m_axil_wdata;
      end
   end

   // Per-cycle history of the last run (cycle 0 = start sampled).
   logic h_aw [64];
   logic h_w [64];
   logic h_b [64];
   logic h_busy [64];
   logic h_tready [64];
   logic h_err [64];
   int   run_cycles;
   logic done_err;
   logic done_busy;

   task automatic clear_env();
      @(negedge fsm_clk); tb_clr = 1'b1;
      @(negedge fsm_clk); tb_clr = 1'b0;
   endtask

   task automatic do_run(input logic [31:0] base, input logic [32:0] size);
      for (int i = 0; i < 64; i++) begin
         h_aw[i] = 0; h_w[i] = 0; h_b[i] = 0; h_busy[i] = 0; h_tready[i] = 0; h_err[i] = 0;
      end
      run_cycles = -1; done_err = 1'bx; done_busy = 1'bx;
      @(negedge fsm_clk);
      operation_start = 1'b1; base_addr = base; data_size = size;
      @(negedge fsm_clk);
      operation_start = 1'b0;
      for (int c = 1; c < 64; c++) begin
         if (c > 1) @(negedge fsm_clk);
         h_aw[c] = bus.m_axil_awvalid; h_w[c] = bus.m_axil_wvalid; h_b[c] = bus.m_axil_bready;
         h_busy[c] = operation_busy; h_tready[c] = bus.s_axis_tready; h_err[c] = operation_error;
         if (operation_complete) begin
            run_cycles = c; done_err = operation_error; done_busy = operation_busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge fsm_clk);
      n_cmp++;
      if ({operation_busy, operation_complete, operation_error, bus.s_axis_tready,
           bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 0000000", {operation_busy, operation_complete,
                  operation_error, bus.s_axis_tready, bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready});
      end
      n_cmp++;
      if (bus.m_axil_awaddr !== 32'h0 || bus.m_axil_wdata !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_data: awaddr %h wdata %h want 0/0", bus.m_axil_awaddr, bus.m_axil_wdata);
      end
      rst = 1'b0;
      @(negedge fsm_clk);
      n_cmp++;
      if (operation_busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: busy %b tready %b want 0/0", operation_busy, bus.s_axis_tready);
      end
   endtask

   task automatic test_basic();
      aw_delay = 0; w_delay = 0; bad_beat = -1;
      for (int i = 0; i < 4; i++) begin
         s_data[i] = 16'(16'h00A1 + i); s_last[i] = (i == 3);
      end
      s_len = 4;
      clear_env();
      do_run(32'h100, 33'd4);
      n_cmp++;
      if (run_cycles != 13) begin n_bad++; $display("FAIL basic_latency: got %0d want 13", run_cycles); end
      n_cmp++;
      if (done_err !== 1'b0 || done_busy !== 1'b0) begin
         n_bad++; $display("FAIL basic_done: error %b busy %b want 0/0", done_err, done_busy);
      end
      n_cmp++;
      if ({h_busy[1], h_tready[1]} !== 2'b11) begin
         n_bad++; $display("FAIL basic_start: busy,tready %b%b want 11", h_busy[1], h_tready[1]);
      end
      n_cmp++;
      if ({h_aw[2], h_w[2], h_aw[5], h_w[5]} !== 4'b1111) begin
         n_bad++; $display("FAIL basic_turnaround: %b%b%b%b want 1111", h_aw[2], h_w[2], h_aw[5], h_w[5]);
      end
      n_cmp++;
      if (n_aw != 4 || n_w != 4) begin n_bad++; $display("FAIL basic_count: aw %0d w %0d want 4/4", n_aw, n_w); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (log_awaddr[i] !== 32'(32'h100 + 2 * i) || log_wdata[i] !== 16'(16'h00A1 + i)) begin
            n_bad++;
            $display("FAIL basic_beat%0d: addr %h data %h want %h %h", i, log_awaddr[i], log_wdata[i],
                     32'(32'h100 + 2 * i), 16'(16'h00A1 + i));
         end
      end
      n_cmp++;
      if (bus.m_axil_wstrb !== 2'b11 || bus.m_axil_awprot !== 3'b000) begin
         n_bad++; $display("FAIL basic_fixed: wstrb %b awprot %b want 11/000", bus.m_axil_wstrb, bus.m_axil_awprot);
      end
   endtask

   task automatic test_aw_delay();
      logic [2:0] exp_tbl [5] = '{3'b110, 3'b100, 3'b100, 3'b100, 3'b001};
      aw_delay = 3; w_delay = 0; bad_beat = -1;
      s_data[0] = 16'h0055; s_last[0] = 1'b1; s_len = 1;
      clear_env();
      do_run(32'h200, 33'd1);
      for (int c = 2; c <= 6; c++) begin
         n_cmp++;
         if ({h_aw[c], h_w[c], h_b[c]} !== exp_tbl[c-2]) begin
            n_bad++;
            $display("FAIL awdelay_cyc%0d: aw,w,b %b%b%b want %b", c, h_aw[c], h_w[c], h_b[c], exp_tbl[c-2]);
         end
      end
      n_cmp++;
      if (run_cycles != 7) begin n_bad++; $display("FAIL awdelay_latency: got %0d want 7", run_cycles); end
      n_cmp++;
      if (stab_err != 0 || log_awaddr[0] !== 32'h200 || log_wdata[0] !== 16'h0055) begin
         n_bad++;
         $display("FAIL awdelay_stable: unstable %0d addr %h data %h want 0 200 0055", stab_err, log_awaddr[0], log_wdata[0]);
      end
      aw_delay = 0;
   endtask

   task automatic test_bad_resp();
      bad_beat = 1;
      s_data[0] = 16'h0011; s_data[1] = 16'h0022; s_data[2] = 16'h0033;
      s_last[0] = 1'b0; s_last[1] = 1'b0; s_last[2] = 1'b1; s_len = 3;
      clear_env();
      do_run(32'h300, 33'd3);
      n_cmp++;
      if (run_cycles != 10 || done_err !== 1'b1) begin
         n_bad++; $display("FAIL badresp_done: cycles %0d error %b want 10/1", run_cycles, done_err);
      end
      n_cmp++;
      if (h_err[9] !== 1'b0) begin n_bad++; $display("FAIL badresp_early: error %b want 0", h_err[9]); end
      n_cmp++;
      if (n_aw != 3 || n_w != 3 || n_b != 3) begin
         n_bad++; $display("FAIL badresp_count: aw %0d w %0d b %0d want 3/3/3", n_aw, n_w, n_b);
      end
      bad_beat = -1;
   endtask

   task automatic test_tlast_mismatch();
      for (int i = 0; i < 5; i++) begin
         s_data[i] = 16'(16'h00B1 + i); s_last[i] = (i == 1) || (i == 4);
      end
      s_len = 5;
      clear_env();
      do_run(32'h400, 33'd4);
      n_cmp++;
      if (run_cycles != 13 || done_err !== 1'b1) begin
         n_bad++; $display("FAIL tlast_done: cycles %0d error %b want 13/1", run_cycles, done_err);
      end
      n_cmp++;
      if (n_w != 4 || log_wdata[3] !== 16'h00B4) begin
         n_bad++; $display("FAIL tlast_writes: n %0d last %h want 4 00B4", n_w, log_wdata[3]);
      end
      repeat (3) @(negedge fsm_clk);
      n_cmp++;
      if (s_idx != 4 || bus.s_axis_tready !== 1'b0) begin
         n_bad++; $display("FAIL tlast_extra: consumed %0d tready %b want 4/0", s_idx, bus.s_axis_tready);
      end
   endtask

   task automatic test_zero_size();
      s_len = 0;
      clear_env();
      do_run(32'h500, 33'd0);
      n_cmp++;
      if (run_cycles != 1 || done_err !== 1'b0 || done_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_done: cycles %0d error %b busy %b want 1/0/0", run_cycles, done_err, done_busy);
      end
      repeat (2) @(negedge fsm_clk);
      n_cmp++;
      if (n_aw != 0 || operation_busy !== 1'b0) begin
         n_bad++; $display("FAIL zero_quiet: aw %0d busy %b want 0/0", n_aw, operation_busy);
      end
   endtask

   task automatic test_wrap();
      s_data[0] = 16'h00C1; s_data[1] = 16'h00C2; s_last[0] = 1'b0; s_last[1] = 1'b1; s_len = 2;
      clear_env();
      do_run(32'hFFFF_FFFE, 33'd2);
      n_cmp++;
      if (log_awaddr[0] !== 32'hFFFF_FFFE || log_awaddr[1] !== 32'h0000_0000) begin
         n_bad++; $display("FAIL wrap_addr: %h %h want FFFFFFFE 00000000", log_awaddr[0], log_awaddr[1]);
      end
      n_cmp++;
      if (run_cycles != 7 || done_err !== 1'b0) begin
         n_bad++; $display("FAIL wrap_done: cycles %0d error %b want 7/0", run_cycles, done_err);
      end
   endtask

   task automatic test_reset_mid_run();
      aw_delay = 5;
      s_data[0] = 16'h00D1; s_data[1] = 16'h00D2; s_last[0] = 1'b0; s_last[1] = 1'b1; s_len = 2;
      clear_env();
      @(negedge fsm_clk);
      operation_start = 1'b1; base_addr = 32'h600; data_size = 33'd2;
      @(negedge fsm_clk);
      operation_start = 1'b0;
      @(negedge fsm_clk);
      n_cmp++;
      if (bus.m_axil_awvalid !== 1'b1) begin
         n_bad++; $display("FAIL midrst_pre: awvalid %b want 1", bus.m_axil_awvalid);
      end
      rst = 1'b1;
      @(negedge fsm_clk);
      n_cmp++;
      if ({operation_busy, operation_complete, operation_error, bus.s_axis_tready, bus.m_axil_awvalid,
           bus.m_axil_wvalid, bus.m_axil_bready} !== 7'b0 || bus.m_axil_awaddr !== 32'h0
          || bus.m_axil_wdata !== 16'h0) begin
         n_bad++;
         $display("FAIL midrst_outputs: ctrl %b awaddr %h wdata %h want 0", {operation_busy, operation_complete,
                  operation_error, bus.s_axis_tready, bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready},
                  bus.m_axil_awaddr, bus.m_axil_wdata);
      end
      rst = 1'b0;
      aw_delay = 0;
      s_data[0] = 16'h00E1; s_last[0] = 1'b1; s_len = 1;
      clear_env();
      do_run(32'h700, 33'd1);
      n_cmp++;
      if (run_cycles != 4 || done_err !== 1'b0 || n_aw != 1 || log_awaddr[0] !== 32'h700
          || log_wdata[0] !== 16'h00E1) begin
         n_bad++;
         $display("FAIL midrst_rerun: cycles %0d err %b n %0d addr %h data %h want 4 0 1 700 00E1",
                  run_cycles, done_err, n_aw, log_awaddr[0], log_wdata[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      operation_start = 1'b0;
      base_addr = '0;
      data_size = '0;
      for (int i = 0; i < 8; i++) begin
         s_data[i] = '0; s_last[i] = 1'b0;
      end
      test_reset();
      test_basic();
      test_aw_delay();
      test_bad_resp();
      test_tlast_mismatch();
      test_zero_size();
      test_wrap();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
